// File: rtl/data_bus_buffer.sv
// Bidirectional CPU data bus buffer for the PIC. Inbound writes on D are latched
// into PCadr. Outbound data is registered and driven onto D only while enabled.
module data_bus_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] D,
  input  logic             en,
  input  logic             ino,
  input  logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] PCadr,
  output logic             in_valid,
  output logic             d_oe
);

  logic [WIDTH-1:0] pcadr_r;
  logic             in_valid_r;
  logic [WIDTH-1:0] out_r;
  logic             inbound_s;
  logic             outbound_s;

  // An X or Z on en or ino must never enable the bus driver, so only exact
  // 1/0 values count as a direction request.
  always_comb begin
    inbound_s  = 1'b0;
    outbound_s = 1'b0;
    if (en === 1'b1) begin
      if (ino === 1'b1) begin
        inbound_s = 1'b1;
      end else if (ino === 1'b0) begin
        outbound_s = 1'b1;
      end else begin
        inbound_s  = 1'b0;
        outbound_s = 1'b0;
      end
    end else begin
      inbound_s  = 1'b0;
      outbound_s = 1'b0;
    end
  end

  // Latch inbound data, register outbound data, and generate the in_valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcadr_r    <= {WIDTH{1'b0}};
      in_valid_r <= 1'b0;
      out_r      <= {WIDTH{1'b0}};
    end else if (inbound_s) begin
      pcadr_r    <= D;
      in_valid_r <= 1'b1;
    end else if (outbound_s) begin
      out_r      <= out_data;
      in_valid_r <= 1'b0;
    end else begin
      in_valid_r <= 1'b0;
    end
  end

  // The output enable stays combinational so the bus is released in the same
  // cycle that en falls, ino rises, or reset asserts.
  always_comb begin
    d_oe = outbound_s & ~rst;
  end

  assign D        = d_oe ? out_r : {WIDTH{1'bz}};
  assign PCadr    = pcadr_r;
  assign in_valid = in_valid_r;

endmodule

// File: tb/tb_data_bus_buffer.sv
// Self-checking bench for data_bus_buffer: a table of per-cycle vectors plus
// hand-written sequences for direction flips, mid-cycle release and async reset.
module tb_data_bus_buffer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             ino;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] PCadr;
  logic             in_valid;
  logic             d_oe;
  wire  [WIDTH-1:0] D;

  logic             tb_d_en;
  logic [WIDTH-1:0] tb_d_val;

  int pass_cnt;
  int total_cnt;

  assign D = tb_d_en ? tb_d_val : {WIDTH{1'bz}};

  data_bus_buffer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .D        (D),
    .en       (en),
    .ino      (ino),
    .out_data (out_data),
    .PCadr    (PCadr),
    .in_valid (in_valid),
    .d_oe     (d_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       ino;
    logic       drive;
    logic [7:0] din;
    logic [7:0] odata;
    logic [7:0] exp_pcadr;
    logic       exp_valid;
    logic       exp_oe;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    en        = 1'b1;
    ino       = 1'b0;
    out_data  = 8'hC3;
    tb_d_en   = 1'b0;
    tb_d_val  = 8'h00;

    // en, ino, drive, din, odata, exp_pcadr, exp_valid, exp_oe, exp_d
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'hAA, 8'h00, 8'hAA, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'hAA, 8'h00, 8'hAA, 1'b1, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h55, 8'hAA, 1'b0, 1'b1, 8'h55};
    vecs[5]  = '{1'b0, 1'bx, 1'b1, 8'h33, 8'h11, 8'hAA, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{1'b0, 1'bx, 1'b1, 8'h33, 8'h22, 8'hAA, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 1'bx, 1'b1, 8'h33, 8'h44, 8'hAA, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h66, 8'hAA, 1'b0, 1'b1, 8'h66};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'h3C, 8'h77, 8'h3C, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h5A, 8'h3C, 1'b0, 1'b1, 8'h5A};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h0F, 8'h3C, 1'b0, 1'b1, 8'h0F};

    // Reset state, with an outbound request present that must not drive D.
    #2;
    check("rst_pcadr", PCadr, 8'h00);
    check("rst_valid", {7'b0, in_valid}, 8'h00);
    check("rst_oe", {7'b0, d_oe}, 8'h00);
    @(posedge clk);
    #1;
    check("rst_hold_pcadr", PCadr, 8'h00);
    check("rst_hold_oe", {7'b0, d_oe}, 8'h00);

    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      en       = vecs[i].en;
      ino      = vecs[i].ino;
      tb_d_en  = vecs[i].drive;
      tb_d_val = vecs[i].din;
      out_data = vecs[i].odata;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pcadr", i), PCadr, vecs[i].exp_pcadr);
      check($sformatf("v%0d_valid", i), {7'b0, in_valid}, {7'b0, vecs[i].exp_valid});
      check($sformatf("v%0d_oe", i), {7'b0, d_oe}, {7'b0, vecs[i].exp_oe});
      if (vecs[i].exp_oe) begin
        check($sformatf("v%0d_d", i), D, vecs[i].exp_d);
      end
    end

    // Outbound to inbound: d_oe falls before any clock edge, then bench drives D.
    @(negedge clk);
    ino = 1'b1;
    #1;
    check("flip_oe_drop", {7'b0, d_oe}, 8'h00);
    tb_d_en  = 1'b1;
    tb_d_val = 8'hF0;
    @(posedge clk);
    #1;
    check("flip_pcadr", PCadr, 8'hF0);
    check("flip_valid", {7'b0, in_valid}, 8'h01);

    // Inbound to outbound: held out register (0x0F) appears at once, new data next edge.
    @(negedge clk);
    tb_d_en  = 1'b0;
    out_data = 8'h99;
    ino      = 1'b0;
    #1;
    check("i2o_oe", {7'b0, d_oe}, 8'h01);
    check("i2o_held_d", D, 8'h0F);
    @(posedge clk);
    #1;
    check("i2o_new_d", D, 8'h99);
    check("i2o_valid", {7'b0, in_valid}, 8'h00);
    check("i2o_pcadr", PCadr, 8'hF0);

    // en dropped mid-cycle releases D immediately and out register holds.
    @(negedge clk);
    en = 1'b0;
    #1;
    check("en_drop_oe", {7'b0, d_oe}, 8'h00);
    @(posedge clk);
    #1;
    check("en_drop_pcadr", PCadr, 8'hF0);
    @(negedge clk);
    out_data = 8'h55;
    en       = 1'b1;
    #1;
    check("en_back_held_d", D, 8'h99);
    @(posedge clk);
    #1;
    check("out55_d", D, 8'h55);

    // Async reset between edges clears everything with no clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_oe", {7'b0, d_oe}, 8'h00);
    check("arst_pcadr", PCadr, 8'h00);
    check("arst_valid", {7'b0, in_valid}, 8'h00);
    #1;
    rst = 1'b0;
    #1;
    check("arst_out_cleared", D, 8'h00);
    check("arst_rel_oe", {7'b0, d_oe}, 8'h01);
    @(posedge clk);
    #1;
    check("arst_next_d", D, 8'h55);
    check("arst_next_pcadr", PCadr, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_bus_buffer.md
Name: data_bus_buffer

Overview:
- 8-bit bidirectional data bus buffer for the PIC. It sits between the CPU data bus D and the PIC internal bus.
- Inbound (CPU write): the value on D is latched onto the internal address/data bus PCadr.
- Outbound (CPU read, e.g. status or interrupt vector): internal data is driven onto D.
- When not enabled, D is never driven by this block.

Parameters:
- WIDTH, 8, data bus width in bits; all data ports use this width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- D  inout  WIDTH  CPU data bus; sampled when inbound, driven only when outbound.
- en  input  1  buffer enable, active high; 0 = buffer idle, D high-Z, PCadr holds.
- ino  input  1  direction: 1 = inbound (D -> PCadr), 0 = outbound (out_data -> D); ignored when en=0.
- out_data  input  WIDTH  internal data to present on D during outbound cycles.
- PCadr  output  WIDTH  registered internal bus value latched from D.
- in_valid  output  1  one-cycle pulse, high in the cycle after D was latched into PCadr.
- d_oe  output  1  high while this block drives D (for debug and other bus masters).

Behaviour:
- Reset (rst=1, asynchronous, independent of clk):
  - PCadr=0, in_valid=0, d_oe=0, D high-Z, internal out register=0.
  - Takes effect immediately and holds while rst=1; first update on the first rising clk edge after rst falls.
- Inbound, en=1 and ino=1:
  - On each rising clk edge, PCadr <= D and in_valid <= 1.
  - Latency: one clock from D to PCadr.
  - D is not driven; d_oe=0.
  - If en and ino stay asserted across several edges, PCadr tracks D every edge and in_valid stays high.
- Outbound, en=1 and ino=0:
  - On each rising edge, out register <= out_data.
  - D = out register; d_oe=1 (combinational from en/ino, registered data).
  - So D shows out_data one clock after it is presented; the value is stable between edges.
  - PCadr holds its value; in_valid <= 0.
- Idle, en=0:
  - D high-Z; d_oe=0; PCadr holds; in_valid <= 0; out register holds.
  - ino is don't-care, including X/Z.
- Direction switch:
  - Outbound to inbound: d_oe drops combinationally in the same cycle ino rises, so there is no bus contention.
  - Inbound to outbound: D drives the currently held out register immediately; it updates to the new out_data at the next edge.
- en deassert mid-transfer: D released combinationally; no partial latch occurs (sampling only at the clock edge).
- Reset during an active transfer: outputs clear and D is released immediately; any pending latch is discarded.
- Arithmetic: none; pure bitwise transfer, no width extension or truncation (all buses WIDTH bits).
- X on D during inbound is latched as-is; X on en is treated as not enabled for output drive (d_oe must not be X; use en===1 semantics in the output enable).

Test Plan:
- Reset: rst=1, with D undriven by the bench and any en/ino -> PCadr=0x00, in_valid=0, d_oe=0, D reads Z. Release rst, en=0, D=0x00, wait 2 clocks -> PCadr stays 0x00.
- Inbound latch: en=1, ino=1, D=0xAA -> after the next rising edge PCadr=0xAA, in_valid=1 for that cycle, d_oe=0 throughout; hold D=0xAA an extra cycle -> in_valid stays 1, PCadr=0xAA.
- Outbound drive: bench releases D; en=1, ino=0, out_data=0x55 -> after one edge D=0x55, d_oe=1, PCadr still 0xAA, in_valid=0.
- Idle and hold: en=0, ino=X, D driven 0x33 by the bench -> d_oe=0, no contention, PCadr remains 0xAA, in_valid=0 for 3 clocks.
- Direction flip: outbound with out_data=0x0F, then ino 0->1 mid-cycle -> d_oe falls in the same cycle; bench drives D=0xF0 -> PCadr=0xF0 after the next edge.
- Async reset mid-operation: during outbound (D=0x55), pulse rst between clock edges -> D goes Z and PCadr=0x00 immediately without a clock edge; after release the out register is 0x00 until the next enabled edge.
